// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_pkg                                                  |
// | Description : Shared types and constants for the User/System mode          |
// |               general-purpose register file (R0-R15).                      |
// | Contents    : DATA_W, ADDR_W, NUM_REGS, reg_data_t, reg_addr_t,            |
// |               RESET_VAL, and the SP/LR/PC register indices used by the     |
// |               surrounding datapath.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_data_t RESET_VAL = 32'h0000_0000;

  // Architectural aliases; no special behaviour inside the register file.
  localparam reg_addr_t SP = 4'd13;
  localparam reg_addr_t LR = 4'd14;
  localparam reg_addr_t PC = 4'd15;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_read_port                                            |
// | Description : One combinational read port: 2^ADDR_W:1 mux over the         |
// |               register array, with optional write-through forwarding.      |
// | Ports       : i_rd_addr  - register index to read                          |
// |               i_regs     - flattened register array contents               |
// |               i_wr_en    - write enable already qualified by reset         |
// |               i_wr_addr  - write index (forwarding compare)                |
// |               i_wr_data  - write data (forwarding source)                  |
// |               o_rd_data  - selected register value                         |
// | Config      : REGFILE_BYPASS_EN - forward write data on address match      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0]                     i_rd_addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    i_regs,
  input  logic                                  i_wr_en,
  input  logic [ADDR_W-1:0]                     i_wr_addr,
  input  logic [DATA_W-1:0]                     i_wr_data,
  output logic [DATA_W-1:0]                     o_rd_data
);

`ifdef REGFILE_BYPASS_EN
  // A write in flight to the addressed register wins over the stored value,
  // so the consumer sees the new data in the same cycle it is written.
  always_comb begin
    o_rd_data = i_regs[i_rd_addr];
    if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      o_rd_data = i_wr_data;
    end
  end
`else
  assign o_rd_data = i_regs[i_rd_addr];

  // Write-side inputs only matter when forwarding is built in.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_wr_en, i_wr_addr, i_wr_data};
`endif

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_user_sys_state.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_user_sys_state                                       |
// | Description : ARMv7 User/System mode register file, 16 x 32-bit unbanked   |
// |               registers, three combinational read ports, one synchronous   |
// |               write port, asynchronous active-low reset.                   |
// | Ports       : clk        - clock, writes on rising edge                    |
// |               Rst        - asynchronous active-low reset, clears all regs  |
// |               R_Addr_A/B/C - read indices                                  |
// |               W_Addr, W_Data, Write_Reg - write port                       |
// |               R_Data_A/B/C - read data                                     |
// | Config      : REGFILE_BYPASS_EN - same-cycle write-through forwarding on   |
// |               each read port (default build: no forwarding)                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_user_sys_state
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] R_Addr_C,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Write_Reg,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic [DATA_W-1:0] R_Data_C
);

  localparam int C_NUM_REGS = 1 << ADDR_W;

  logic [C_NUM_REGS-1:0][DATA_W-1:0] r_regs;

  // Qualified with Rst so forwarding never leaks data while reset is held.
  logic w_wr_en;
  assign w_wr_en = Write_Reg & Rst;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(RESET_VAL);
      end
    end else if (w_wr_en) begin
      r_regs[W_Addr] <= W_Data;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .i_rd_addr (R_Addr_A),
    .i_regs    (r_regs),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (W_Addr),
    .i_wr_data (W_Data),
    .o_rd_data (R_Data_A)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .i_rd_addr (R_Addr_B),
    .i_regs    (r_regs),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (W_Addr),
    .i_wr_data (W_Data),
    .o_rd_data (R_Data_B)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_c (
    .i_rd_addr (R_Addr_C),
    .i_regs    (r_regs),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (W_Addr),
    .i_wr_data (W_Data),
    .o_rd_data (R_Data_C)
  );

endmodule : regfile_user_sys_state
`default_nettype wire

// File: tb/tb_regfile_user_sys_state.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_user_sys_state                                    |
// | Description : Scoreboard bench for regfile_user_sys_state. A driver issues |
// |               one access per cycle and queues the expected read data from  |
// |               an array model; a monitor compares at the falling edge.      |
// | Config      : REGFILE_BYPASS_EN - expectations follow forwarding rules     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_regfile_user_sys_state;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic [3:0]  R_Addr_A = 4'd0;
  logic [3:0]  R_Addr_B = 4'd0;
  logic [3:0]  R_Addr_C = 4'd0;
  logic [3:0]  W_Addr = 4'd0;
  logic [31:0] W_Data = 32'h0;
  logic        Write_Reg = 1'b0;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;
  logic [31:0] R_Data_C;

  regfile_user_sys_state #(
    .DATA_W (32),
    .ADDR_W (4)
  ) dut (
    .clk       (clk),
    .Rst       (Rst),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .R_Addr_C  (R_Addr_C),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .Write_Reg (Write_Reg),
    .R_Data_A  (R_Data_A),
    .R_Data_B  (R_Data_B),
    .R_Data_C  (R_Data_C)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ra, rb, rc;
    logic [31:0] a, b, c;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model[16];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Expected read value for the inputs being applied this cycle.
  function automatic logic [31:0] exp_rd(input logic [3:0] a, input logic rst,
                                         input logic we, input logic [3:0] wa,
                                         input logic [31:0] wd);
    logic [31:0] v;
    v = rst ? model[a] : 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (rst && we && (a == wa)) v = wd;
`endif
    return v;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic rst, input logic we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] rc);
    exp_t e;
    Rst = rst; Write_Reg = we; W_Addr = wa; W_Data = wd;
    R_Addr_A = ra; R_Addr_B = rb; R_Addr_C = rc;
    if (!rst) begin
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
    end
    e.ra = ra; e.rb = rb; e.rc = rc;
    e.a = exp_rd(ra, rst, we, wa, wd);
    e.b = exp_rd(rb, rst, we, wa, wd);
    e.c = exp_rd(rc, rst, we, wa, wd);
    sb_q.push_back(e);
    @(posedge clk);
    if (rst && we) model[wa] = wd;
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] addr,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s addr=%0d got=%08h expected=%08h t=%0t", name, addr, act, exp, $time);
    end
  endtask

  // Monitor: read ports are combinational, so compare mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("port_A", e.ra, R_Data_A, e.a);
      chk("port_B", e.rb, R_Data_B, e.b);
      chk("port_C", e.rc, R_Data_C, e.c);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    @(posedge clk);
    #1;

    // Reset: every address reads zero; writes are ignored while held.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'(i), 32'hFFFF_FFFF, 4'(i), 4'(15 - i), 4'((i + 5) % 16));
    end

    // Basic writes, then read back.
    step(1'b1, 1'b1, 4'd1, 32'hAC96_3A55, 4'd1, 4'd2, 4'd3);
    step(1'b1, 1'b1, 4'd2, 32'h1111_1111, 4'd1, 4'd2, 4'd3);
    step(1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'd1, 4'd2, 4'd3);
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'd1, 4'd2, 4'd3);

    // Write-enable gating.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd1, 32'h0, 4'd1, 4'd1, 4'd1);

    // Full sweep including R15, then read every address and alias on R7.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 4'(i), 32'h1000_0000 + i, 4'(i), 4'((i + 1) % 16), 4'd15);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'd0, 32'h0, 4'(i), 4'(15 - i), 4'((i + 7) % 16));
    end
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'd7, 4'd7, 4'd7);

    // Same-cycle write/read hazard on R4.
    step(1'b1, 1'b1, 4'd4, 32'hDEAD_BEEF, 4'd4, 4'd4, 4'd0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'd4, 4'd4, 4'd4);

    // Reset asserted between edges with a write pending: all zero, write dropped.
    step(1'b0, 1'b1, 4'd5, 32'h1234_5678, 4'd1, 4'd7, 4'd15);
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'd5, 4'd1, 4'd7);

    // Randomised traffic with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0),
           4'($urandom_range(0, 15)), 32'($urandom()),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    Write_Reg = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_user_sys_state
`default_nettype wire
